// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Bus widths, reset level, zero word and the fetch FSM encoding.
package if_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;
    localparam int MemByteBus  = 8;

    localparam logic [InstBus-1:0] ZeroWord  = '0;
    localparam logic               RstEnable = 1'b1;

    // Number of byte reads that make up one instruction word
    localparam logic [2:0] BytesPerInst = 3'd4;

    typedef enum logic {
        IF_FETCH = 1'b0,
        IF_HOLD  = 1'b1
    } if_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: four byte reads per 32-bit word, little-endian.
// Ports: clk/rst (sync high), branch_*_i redirect, mem_* byte port,
//        inst_valid_o/id_ready_i handshake, pc_o/inst_o to decode.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_i,
    output logic                   mem_req_o,
    output logic [InstAddrBus-1:0] mem_a_o,
    input  logic                   mem_grant_i,
    input  logic [MemByteBus-1:0]  mem_din_i,
    output logic                   inst_valid_o,
    input  logic                   id_ready_i,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o
);

    if_state_e              r_state;
    logic [InstAddrBus-1:0] r_pc;
    logic [InstBus-1:0]     r_buf;
    logic [2:0]             r_issue;
    logic [2:0]             r_recv;
    logic                   r_pend;
    logic                   r_valid;

    logic                   w_req;
    logic                   w_fire;

    // Request is suppressed while reset or a redirect is being taken
    assign w_req = (r_state == IF_FETCH)
                && (r_issue < BytesPerInst)
                && (rst != RstEnable)
                && !branch_flag_i;
    assign w_fire = w_req & mem_grant_i;

    assign mem_req_o    = w_req;
    assign mem_a_o      = r_pc + {29'b0, r_issue};
    assign inst_valid_o = r_valid;
    assign pc_o         = r_pc;
    assign inst_o       = r_buf;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state <= IF_FETCH;
            r_pc    <= RESET_PC;
            r_buf   <= ZeroWord;
            r_issue <= 3'd0;
            r_recv  <= 3'd0;
            r_pend  <= 1'b0;
            r_valid <= 1'b0;
        end else if (branch_flag_i) begin
            // Dropping pend discards the byte already in flight
            r_state <= IF_FETCH;
            r_pc    <= branch_target_i;
            r_buf   <= ZeroWord;
            r_issue <= 3'd0;
            r_recv  <= 3'd0;
            r_pend  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IF_FETCH: begin
                    r_pend <= w_fire;
                    if (w_fire) begin
                        r_issue <= r_issue + 3'd1;
                    end
                    if (r_pend) begin
                        r_buf[{r_recv[1:0], 3'b000} +: 8] <= mem_din_i;
                        r_recv <= r_recv + 3'd1;
                        if (r_recv == BytesPerInst - 3'd1) begin
                            r_valid <= 1'b1;
                            r_state <= IF_HOLD;
                        end
                    end
                end
                IF_HOLD: begin
                    if (id_ready_i) begin
                        r_pc    <= r_pc + 32'd4;
                        r_buf   <= ZeroWord;
                        r_issue <= 3'd0;
                        r_recv  <= 3'd0;
                        r_pend  <= 1'b0;
                        r_valid <= 1'b0;
                        r_state <= IF_FETCH;
                    end
                end
                default: r_state <= IF_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: vector table, directed corner cases,
// and random traffic against a word-level reference model.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        mem_req_o;
    logic [31:0] mem_a_o;
    logic        mem_grant_i;
    logic [7:0]  mem_din_i;
    logic        inst_valid_o;
    logic        id_ready_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;

    if_fetch #(.RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .mem_req_o      (mem_req_o),
        .mem_a_o        (mem_a_o),
        .mem_grant_i    (mem_grant_i),
        .mem_din_i      (mem_din_i),
        .inst_valid_o   (inst_valid_o),
        .id_ready_i     (id_ready_i),
        .pc_o           (pc_o),
        .inst_o         (inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];

    // Synchronous byte memory: data one cycle after a granted request,
    // garbage otherwise so stray captures show up.
    always @(posedge clk) begin
        if (mem_req_o && mem_grant_i)
            mem_din_i <= mem[mem_a_o[9:0]];
        else
            mem_din_i <= 8'($urandom);
    end

    int vectors = 0;
    int errs    = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] ak;
            ak = a + 32'(k);
            w[8*k +: 8] = mem[ak[9:0]];
        end
        return w;
    endfunction

    // Reference model: how many bytes of the word at m_pc have been
    // requested / delivered, and whether one is on its way.
    logic [31:0] m_pc;
    int          m_issued;
    int          m_got;
    bit          m_pend;
    bit          m_valid;

    task automatic model_clear(input logic [31:0] pc);
        m_pc     = pc;
        m_issued = 0;
        m_got    = 0;
        m_pend   = 0;
        m_valid  = 0;
    endtask

    task automatic model_update();
        bit req;
        if (rst) begin
            model_clear(32'h0);
        end else if (branch_flag_i) begin
            model_clear(branch_target_i);
        end else if (m_valid) begin
            if (id_ready_i) model_clear(m_pc + 32'd4);
        end else begin
            req = (m_issued < 4);
            if (m_pend) begin
                m_got++;
                if (m_got == 4) m_valid = 1;
            end
            m_pend = req && mem_grant_i;
            if (m_pend) m_issued++;
        end
    endtask

    task automatic compare_model(input string tag);
        bit exp_req;
        exp_req = !rst && !branch_flag_i && !m_valid && (m_issued < 4);
        check({tag, ".req"},   32'(mem_req_o), 32'(exp_req));
        check({tag, ".addr"},  mem_a_o, m_pc + 32'(m_issued));
        check({tag, ".valid"}, 32'(inst_valid_o), 32'(m_valid));
        check({tag, ".pc"},    pc_o, m_pc);
        if (m_valid)
            check({tag, ".inst"}, inst_o, word_at(m_pc));
        else if (m_got == 0)
            check({tag, ".inst0"}, inst_o, 32'h0);
    endtask

    task automatic apply(input logic r, input logic g, input logic rdy,
                         input logic br, input logic [31:0] tg);
        rst             = r;
        mem_grant_i     = g;
        id_ready_i      = rdy;
        branch_flag_i   = br;
        branch_target_i = tg;
        #1;
    endtask

    task automatic clock();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step(input logic r, input logic g, input logic rdy,
                        input logic br, input logic [31:0] tg,
                        input string tag);
        apply(r, g, rdy, br, tg);
        compare_model(tag);
        clock();
    endtask

    task automatic do_reset();
        step(1, 1, 0, 0, 32'h0, "rst");
    endtask

    typedef struct {
        logic        r, g, rdy, br;
        logic [31:0] tg;
        logic        req;
        logic [31:0] a;
        logic        v;
        logic [31:0] pc;
        logic        ichk;
        logic [31:0] inst;
    } vec_t;

    vec_t tab [8];
    int   addr_exp [8] = '{0, 1, 1, 1, 2, 3, 4, 4};
    int   gl_pat   [8] = '{1, 0, 0, 1, 1, 1, 1, 1};

    initial begin
        int first_v;
        int n;

        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'h10; mem[3] = 8'h00;

        tab[0] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0};
        tab[1] = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 32'h0};
        tab[2] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 32'h0};
        tab[3] = '{0, 1, 1, 0, 0, 1, 2, 0, 0, 0, 32'h0};
        tab[4] = '{0, 1, 1, 0, 0, 1, 3, 0, 0, 0, 32'h0};
        tab[5] = '{0, 1, 1, 0, 0, 0, 4, 0, 0, 0, 32'h0};
        tab[6] = '{0, 1, 1, 0, 0, 0, 4, 1, 0, 1, 32'h00100093};
        tab[7] = '{0, 1, 1, 0, 0, 1, 4, 0, 4, 1, 32'h0};

        model_clear(32'h0);
        rst = 1; mem_grant_i = 0; id_ready_i = 0;
        branch_flag_i = 0; branch_target_i = 0;
        @(negedge clk);
        apply(1, 0, 0, 0, 32'h0);
        clock();

        for (int i = 0; i < 8; i++) begin
            apply(tab[i].r, tab[i].g, tab[i].rdy, tab[i].br, tab[i].tg);
            check($sformatf("tab%0d.req", i), 32'(mem_req_o), 32'(tab[i].req));
            check($sformatf("tab%0d.addr", i), mem_a_o, tab[i].a);
            check($sformatf("tab%0d.valid", i), 32'(inst_valid_o),
                  32'(tab[i].v));
            check($sformatf("tab%0d.pc", i), pc_o, tab[i].pc);
            if (tab[i].ichk)
                check($sformatf("tab%0d.inst", i), inst_o, tab[i].inst);
            clock();
        end

        do_reset();
        first_v = -1;
        for (int k = 0; k < 8; k++) begin
            apply(0, 1'(gl_pat[k]), 0, 0, 32'h0);
            compare_model("glow");
            check($sformatf("glow.a%0d", k), mem_a_o, 32'(addr_exp[k]));
            if (inst_valid_o && first_v < 0) first_v = k;
            clock();
        end
        check("glow.latency", 32'(first_v), 32'd7);

        for (int k = 0; k < 10; k++) begin
            apply(0, 1, 0, 0, 32'h0);
            compare_model("hold");
            check("hold.inst", inst_o, 32'h00100093);
            check("hold.req", 32'(mem_req_o), 32'd0);
            clock();
        end
        step(0, 1, 1, 0, 32'h0, "accept");
        apply(0, 1, 0, 0, 32'h0);
        check("next.addr", mem_a_o, 32'h4);
        check("next.req", 32'(mem_req_o), 32'd1);
        clock();

        do_reset();
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 32'h0, "pre_br");
        step(0, 1, 1, 1, 32'h100, "br");
        apply(0, 1, 0, 0, 32'h0);
        check("br.addr", mem_a_o, 32'h100);
        check("br.valid", 32'(inst_valid_o), 32'd0);
        compare_model("br1");
        clock();
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 32'h0, "br_fill");
        apply(0, 1, 0, 0, 32'h0);
        check("br.pc", pc_o, 32'h100);
        check("br.inst", inst_o, word_at(32'h100));
        clock();

        step(0, 1, 1, 1, 32'h200, "br_hs");
        apply(0, 1, 0, 0, 32'h0);
        check("br_hs.pc", pc_o, 32'h200);
        check("br_hs.valid", 32'(inst_valid_o), 32'd0);
        clock();

        do_reset();
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 32'h0, "pre_rst");
        step(1, 1, 1, 1, 32'h300, "mid_rst");
        apply(0, 1, 0, 0, 32'h0);
        check("rst.pc", pc_o, 32'h0);
        check("rst.addr", mem_a_o, 32'h0);
        check("rst.inst", inst_o, 32'h0);
        check("rst.valid", 32'(inst_valid_o), 32'd0);
        check("rst.req", 32'(mem_req_o), 32'd1);
        clock();
        n = 0;
        while (!inst_valid_o && n < 20) begin
            step(0, 1, 0, 0, 32'h0, "refetch");
            n++;
        end
        check("refetch.inst", inst_o, 32'h00100093);
        check("refetch.bound", 32'(n < 20), 32'd1);

        for (int k = 0; k < 1500; k++) begin
            logic        r, g, rdy, br;
            logic [31:0] tg;
            r   = ($urandom_range(0, 99) == 0);
            g   = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 1) == 1);
            br  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0)
                tg = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else
                tg = $urandom;
            step(r, g, rdy, br, tg, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
